// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - shared types for the mpmc11 read-return path
package mpmc11_pkg;

  localparam int MPMC11_NCH = 8;
  localparam int MPMC11_CHW = $clog2(MPMC11_NCH);

  typedef struct packed {
    logic [MPMC11_CHW-1:0] ch;
    logic [3:0]            beats;
  } mpmc11_rd_tag_t;

  typedef enum logic {RDC_IDLE, RDC_ACTIVE} mpmc11_rdc_state_t;

  // Zero-length reads carry one beat; oversize requests clamp to the 3-bit counter range.
  function automatic logic [3:0] rd_beats_norm(input logic [3:0] b);
    if (b == 4'd0) return 4'd1;
    if (b > 4'd8) return 4'd8;
    return b;
  endfunction

endpackage

// File: rtl/mpmc11_rd_tag_fifo.sv
// rtl/mpmc11_rd_tag_fifo.sv - first-word-fall-through store of outstanding read tags
module mpmc11_rd_tag_fifo
  import mpmc11_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  mpmc11_rd_tag_t wdata,
  input  logic           pop,
  output mpmc11_rd_tag_t rdata,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           empty
);

  mpmc11_rd_tag_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Caller qualifies push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mpmc11_rd_data_collect.sv
// rtl/mpmc11_rd_data_collect.sv - steers memory read beats back to the issuing channel
module mpmc11_rd_data_collect
  import mpmc11_pkg::*;
#(
  parameter int WID   = 256,
  parameter int NCH   = 8,
  parameter int DEPTH = 8,
  localparam int CHW  = $clog2(NCH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_push,
  input  logic [CHW-1:0] req_ch,
  input  logic [3:0]     req_beats,
  output logic           req_full,
  input  logic           app_rd_data_valid,
  input  logic [WID-1:0] app_rd_data,
  input  logic           app_rd_data_end,
  output logic [WID-1:0] dato,
  output logic [CHW-1:0] dato_ch,
  output logic           dato_valid,
  output logic           dato_last,
  output logic           err_unexp,
  output logic           err_len,
  output logic           err_ovf
);

  mpmc11_rdc_state_t state, state_nxt;
  mpmc11_rd_tag_t    tag_in, head;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic [2:0]        beat_cnt;
  logic              beat_ok, last, pop, push_ok;

  assign tag_in.ch    = req_ch;
  assign tag_in.beats = rd_beats_norm(req_beats);

  assign beat_ok = app_rd_data_valid & (state == RDC_ACTIVE) & ~empty;
  assign last    = ({1'b0, beat_cnt} == head.beats - 4'd1);
  assign pop     = beat_ok & last;
  // A pop in the same cycle frees the slot, so a push alongside it is still taken.
  assign push_ok = req_push & (~full | pop);

  mpmc11_rd_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (tag_in),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign req_full = full;

  always_comb begin
    state_nxt = state;
    case (state)
      RDC_IDLE:   if (count != '0) state_nxt = RDC_ACTIVE;
      RDC_ACTIVE: if (empty || (pop && count == CW'(1) && !push_ok)) state_nxt = RDC_IDLE;
      default:    state_nxt = RDC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RDC_IDLE;
      beat_cnt   <= '0;
      dato       <= '0;
      dato_ch    <= '0;
      dato_valid <= 1'b0;
      dato_last  <= 1'b0;
      err_unexp  <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_nxt;
      dato_valid <= beat_ok;
      dato_last  <= pop;
      if (beat_ok) begin
        beat_cnt <= last ? 3'd0 : beat_cnt + 3'd1;
        dato     <= app_rd_data;
        dato_ch  <= head.ch;
        if (app_rd_data_end != last) err_len <= 1'b1;
      end
      if (app_rd_data_valid && !beat_ok) err_unexp <= 1'b1;
      if (req_push && !push_ok) err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpmc11_rd_data_collect.sv
// tb/tb_mpmc11_rd_data_collect.sv - directed self-checking bench for mpmc11_rd_data_collect
module tb_mpmc11_rd_data_collect;

  localparam int WID = 256;
  localparam int NCH = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_push;
  logic [2:0]     req_ch;
  logic [3:0]     req_beats;
  logic           req_full;
  logic           app_rd_data_valid;
  logic [WID-1:0] app_rd_data;
  logic           app_rd_data_end;
  logic [WID-1:0] dato;
  logic [2:0]     dato_ch;
  logic           dato_valid;
  logic           dato_last;
  logic           err_unexp;
  logic           err_len;
  logic           err_ovf;

  int n_chk = 0;
  int n_err = 0;

  mpmc11_rd_data_collect #(.WID(WID), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_push          (req_push),
    .req_ch            (req_ch),
    .req_beats         (req_beats),
    .req_full          (req_full),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data       (app_rd_data),
    .app_rd_data_end   (app_rd_data_end),
    .dato              (dato),
    .dato_ch           (dato_ch),
    .dato_valid        (dato_valid),
    .dato_last         (dato_last),
    .err_unexp         (err_unexp),
    .err_len           (err_len),
    .err_ovf           (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WID-1:0] mk(input logic [31:0] n);
    return {8{n}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [3:0] beats);
    req_push = 1'b1; req_ch = ch; req_beats = beats;
    tick();
    req_push = 1'b0;
  endtask

  // Drives one beat and checks the registered result one cycle later.
  task automatic beat(input string tag, input logic [31:0] d, input logic e,
                      input logic [2:0] ch, input logic lst);
    app_rd_data_valid = 1'b1; app_rd_data = mk(d); app_rd_data_end = e;
    tick();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    chk({tag, "_v"}, WID'(dato_valid), WID'(1));
    chk({tag, "_d"}, dato, mk(d));
    chk({tag, "_ch"}, WID'(dato_ch), WID'(ch));
    chk({tag, "_last"}, WID'(dato_last), WID'(lst));
  endtask

  initial begin
    rst = 1'b1; req_push = 1'b0; req_ch = '0; req_beats = '0;
    app_rd_data_valid = 1'b0; app_rd_data = '0; app_rd_data_end = 1'b0;
    tick(); tick();
    chk("rst_valid", WID'(dato_valid), WID'(0));
    chk("rst_dato", dato, '0);
    chk("rst_full", WID'(req_full), WID'(0));
    chk("rst_errs", WID'({err_unexp, err_len, err_ovf}), WID'(0));
    rst = 1'b0;
    tick();

    // 1: ch3, 4 beats
    push(3'd3, 4'd4);
    tick();
    beat("t1_b0", 32'hD000_0000, 1'b0, 3'd3, 1'b0);
    beat("t1_b1", 32'hD000_0001, 1'b0, 3'd3, 1'b0);
    beat("t1_b2", 32'hD000_0002, 1'b0, 3'd3, 1'b0);
    beat("t1_b3", 32'hD000_0003, 1'b1, 3'd3, 1'b1);
    tick();
    chk("t1_gap_v", WID'(dato_valid), WID'(0));
    chk("t1_hold_d", dato, mk(32'hD000_0003));
    chk("t1_idle", WID'(dut.state), WID'(0));

    // 2: ch1/2 then ch5/1, back to back
    push(3'd1, 4'd2);
    push(3'd5, 4'd1);
    tick();
    beat("t2_b0", 32'hA0, 1'b0, 3'd1, 1'b0);
    beat("t2_b1", 32'hA1, 1'b1, 3'd1, 1'b1);
    beat("t2_b2", 32'hA2, 1'b1, 3'd5, 1'b1);
    tick();
    chk("t2_idle", WID'(dut.state), WID'(0));
    chk("t2_errs", WID'({err_unexp, err_len, err_ovf}), WID'(0));

    // 3: fill, overflow, push+pop while full
    push(3'd0, 4'd1);
    push(3'd1, 4'd1);
    push(3'd2, 4'd1);
    push(3'd3, 4'd1);
    chk("t3_full", WID'(req_full), WID'(1));
    chk("t3_no_ovf", WID'(err_ovf), WID'(0));
    push(3'd6, 4'd1);
    chk("t3_ovf", WID'(err_ovf), WID'(1));
    chk("t3_still_full", WID'(req_full), WID'(1));
    req_push = 1'b1; req_ch = 3'd4; req_beats = 4'd1;
    beat("t3_pp", 32'hC0, 1'b1, 3'd0, 1'b1);
    req_push = 1'b0;
    chk("t3_pp_full", WID'(req_full), WID'(1));
    beat("t3_d1", 32'hC1, 1'b1, 3'd1, 1'b1);
    beat("t3_d2", 32'hC2, 1'b1, 3'd2, 1'b1);
    beat("t3_d3", 32'hC3, 1'b1, 3'd3, 1'b1);
    beat("t3_d4", 32'hC4, 1'b1, 3'd4, 1'b1);
    tick();
    chk("t3_empty_full", WID'(req_full), WID'(0));
    chk("t3_idle", WID'(dut.state), WID'(0));

    // 4: unexpected beat, then a length error
    app_rd_data_valid = 1'b1; app_rd_data = mk(32'hEE); app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    chk("t4_unexp_v", WID'(dato_valid), WID'(0));
    chk("t4_unexp_hold", dato, mk(32'hC4));
    chk("t4_unexp", WID'(err_unexp), WID'(1));
    chk("t4_len0", WID'(err_len), WID'(0));
    push(3'd2, 4'd2);
    tick();
    beat("t4_b0", 32'hE0, 1'b1, 3'd2, 1'b0);
    chk("t4_len", WID'(err_len), WID'(1));
    beat("t4_b1", 32'hE1, 1'b1, 3'd2, 1'b1);
    chk("t4_len_sticky", WID'(err_len), WID'(1));

    // 5: asynchronous reset mid-burst
    push(3'd6, 4'd4);
    tick();
    beat("t5_b0", 32'hF0, 1'b0, 3'd6, 1'b0);
    beat("t5_b1", 32'hF1, 1'b0, 3'd6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_v", WID'(dato_valid), WID'(0));
    chk("t5_rst_d", dato, '0);
    chk("t5_rst_ch", WID'(dato_ch), WID'(0));
    chk("t5_rst_errs", WID'({err_unexp, err_len, err_ovf}), WID'(0));
    tick();
    rst = 1'b0;
    chk("t5_rst_idle", WID'(dut.state), WID'(0));
    tick();
    push(3'd4, 4'd2);
    tick();
    beat("t5_g0", 32'h60, 1'b0, 3'd4, 1'b0);
    beat("t5_g1", 32'h61, 1'b1, 3'd4, 1'b1);

    // 6: zero beats treated as one
    push(3'd7, 4'd0);
    tick();
    beat("t6_b0", 32'h70, 1'b1, 3'd7, 1'b1);
    tick();
    chk("t6_idle", WID'(dut.state), WID'(0));
    chk("t6_errs", WID'({err_unexp, err_len, err_ovf}), WID'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
